otter_fetch_queue: RTL and testbench

Instruction-fetch front end for the pipelined OTTER. It owns the fetch PC and issues word reads to instruction memory port 1, which has a 1-cycle synchronous read. It buffers returned {pc, ir} pairs in a small FIFO and hands them to the decode stage over a valid/ready handshake. It accepts a redirect (branch/jump taken in EX) that flushes all buffered and in-flight fetches and restarts fetch at the target PC.

---
 rtl/otter_fetch_queue.sv | 84 ++++++++
 tb/tb_otter_fetch_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/otter_fetch_queue.sv
// rtl/otter_fetch_queue.sv - OTTER instruction-fetch front end with {pc, ir} queue and redirect flush
module otter_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_rden,
   output logic [13:0] imem_addr,
   input  logic [31:0] imem_dout,
   output logic        de_valid,
   input  logic        de_ready,
   output logic [31:0] de_pc,
   output logic [31:0] de_ir
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h00000013;

   logic [31:0] fetch_pc;
   logic [31:0] inflight_pc;
   logic        inflight;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0] pc_q [DEPTH];
   logic [31:0] ir_q [DEPTH];

   logic        pop;
   logic        push;
   logic [CW:0] reserved;

   assign de_valid = ~RESET & (count != '0);
   assign de_pc    = RESET ? 32'h0 : pc_q[rd_ptr];
   assign de_ir    = RESET ? NOP   : ir_q[rd_ptr];

   assign pop  = de_valid & de_ready & ~redirect;
   assign push = inflight & ~redirect;

   // Slots already promised to queued entries plus the outstanding read.
   assign reserved  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign imem_rden = ~RESET & ~redirect & (reserved < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc[15:2];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i] <= 32'h0;
            ir_q[i] <= NOP;
         end
      end else if (redirect) begin
         // The response landing this cycle belongs to the squashed path.
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (imem_rden) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight_pc <= fetch_pc;
         end
         inflight <= imem_rden;
         if (push) begin
            pc_q[wr_ptr] <= inflight_pc;
            ir_q[wr_ptr] <= imem_dout;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb/tb_otter_fetch_queue.sv - directed bench for otter_fetch_queue
module tb_otter_fetch_queue;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_rden;
   logic [13:0] imem_addr;
   logic [31:0] imem_dout = 32'h0;
   logic        de_valid;
   logic        de_ready;
   logic [31:0] de_pc;
   logic [31:0] de_ir;

   int passed = 0;
   int total  = 0;
   int n;

   otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
      .CLK(CLK), .RESET(RESET), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_rden(imem_rden), .imem_addr(imem_addr), .imem_dout(imem_dout),
      .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_ir(de_ir)
   );

   always #5 CLK = ~CLK;

   // Word at address k reads back as 0x1000_0000 + k, one cycle after the read.
   always @(posedge CLK)
      if (imem_rden) imem_dout <= 32'h10000000 + {18'b0, imem_addr};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, {31'b0, de_valid}, 32'd1);
      check({tag, "_pc"}, de_pc, pc);
      check({tag, "_ir"}, de_ir, 32'h10000000 + {2'b0, pc[31:2]});
   endtask

   initial begin
      RESET = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; de_ready = 1'b0;
      @(negedge CLK);
      tick; tick;
      check("rst_rden", {31'b0, imem_rden}, 32'd0);
      check("rst_valid", {31'b0, de_valid}, 32'd0);
      check("rst_pc", de_pc, 32'h0);
      check("rst_ir", de_ir, 32'h00000013);

      // Reset then run with decode always ready
      RESET = 1'b0; de_ready = 1'b1; #1;
      check("run_rden0", {31'b0, imem_rden}, 32'd1);
      check("run_addr0", {18'b0, imem_addr}, 32'd0);
      tick;
      check("run_valid1", {31'b0, de_valid}, 32'd0);
      tick;
      check_head("run_c2", 32'h0);
      for (int k = 1; k <= 3; k++) begin
         tick;
         check_head("run_seq", 32'(4 * k));
      end

      // Backpressure until full, then drain
      RESET = 1'b1; de_ready = 1'b0; tick;
      RESET = 1'b0; #1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_rden) begin
            check("full_addr", {18'b0, imem_addr}, 32'(n));
            n++;
         end
         tick;
      end
      check("full_reads", 32'(n), 32'd4);
      check("full_rden", {31'b0, imem_rden}, 32'd0);
      check_head("full_head", 32'h0);
      de_ready = 1'b1; #1;
      check("drain_rden", {31'b0, imem_rden}, 32'd1);
      check("drain_addr", {18'b0, imem_addr}, 32'd4);
      for (int k = 0; k < 6; k++) begin
         check_head("drain_seq", 32'(4 * k));
         tick;
      end

      // Redirect mid-stream
      redirect = 1'b1; redirect_pc = 32'h00000100; #1;
      check("redir_rden", {31'b0, imem_rden}, 32'd0);
      tick;
      redirect = 1'b0; #1;
      check("redir_addr", {18'b0, imem_addr}, 32'h040);
      check("redir_rden1", {31'b0, imem_rden}, 32'd1);
      check("redir_v1", {31'b0, de_valid}, 32'd0);
      tick;
      check("redir_v2", {31'b0, de_valid}, 32'd0);
      tick;
      check_head("redir_t3", 32'h100);
      tick;
      check_head("redir_t4", 32'h104);

      // Back-to-back redirects: the second wins
      redirect = 1'b1; redirect_pc = 32'h00000200; tick;
      redirect_pc = 32'h00000300; #1;
      check("b2b_rden", {31'b0, imem_rden}, 32'd0);
      tick;
      redirect = 1'b0; #1;
      check("b2b_addr", {18'b0, imem_addr}, 32'h0C0);
      tick;
      check("b2b_v", {31'b0, de_valid}, 32'd0);
      tick;
      check_head("b2b_first", 32'h300);

      // Reset with three queued entries and a read outstanding
      de_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000400; tick;
      redirect = 1'b0;
      tick; tick; tick; tick;
      check_head("mid_head", 32'h400);
      RESET = 1'b1; #1;
      check("mid_rst_v0", {31'b0, de_valid}, 32'd0);
      tick;
      check("mid_rst_v", {31'b0, de_valid}, 32'd0);
      check("mid_rst_ir", de_ir, 32'h00000013);
      check("mid_rst_pc", de_pc, 32'h0);
      RESET = 1'b0; de_ready = 1'b1; #1;
      check("mid_rel_rden", {31'b0, imem_rden}, 32'd1);
      check("mid_rel_addr", {18'b0, imem_addr}, 32'd0);
      tick; tick;
      check_head("mid_rel_head", 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
